// File: rtl/alu_op_sequencer.sv
// Clocked request/response front end for a combinational 16-bit ALU.
// Registers operands, waits a fixed settle time, captures result into acc.
module alu_op_sequencer #(
  parameter int DATA_W        = 16,
  parameter int RES_W         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [3:0]        req_cmd,
  input  logic              req_use_acc,
  input  logic              acc_clear,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_cmd,
  input  logic [RES_W-1:0]  alu_result,
  input  logic [1:0]        alu_error,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [1:0]        rsp_error,
  output logic              rsp_illegal,
  output logic [RES_W-1:0]  acc,
  output logic              busy
);

  localparam int CNT_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;

  logic             legal;
  logic             accept;
  logic             take_ok;
  logic             take_bad;
  logic             capture;
  logic             cnt_dec;
  logic [DATA_W-1:0] op_a;

  assign legal    = (req_cmd <= 4'd4);
  assign accept   = req_valid && req_ready;
  assign take_ok  = accept && legal;
  assign take_bad = accept && !legal;
  assign capture  = (state_q == SETTLE) && (cnt_q == '0);
  assign cnt_dec  = (state_q == SETTLE) && (cnt_q != '0);

  // Pre-edge acc is used even when acc_clear fires on the same edge.
  assign op_a = req_use_acc ? acc[DATA_W-1:0] : req_a;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = legal ? SETTLE : RESP;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cmd <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (1'b1)
        take_ok: begin
          alu_a   <= op_a;
          alu_b   <= req_b;
          alu_cmd <= req_cmd;
          cnt_q   <= CNT_INIT;
        end
        cnt_dec: begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result  <= '0;
      rsp_error   <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      unique case (1'b1)
        take_bad: begin
          rsp_result  <= '0;
          rsp_error   <= '0;
          rsp_illegal <= 1'b1;
        end
        capture: begin
          rsp_result  <= alu_result;
          rsp_error   <= alu_error;
          rsp_illegal <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Divide-by-zero keeps the last good value; overflow still updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clear) begin
      acc <= '0;
    end else if (capture && !alu_error[1]) begin
      acc <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vectors, queue scoreboard,
// behavioural ALU wired to the sequencer's operand outputs.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_cmd;
  logic        req_use_acc;
  logic        acc_clear;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_error;
  logic        rsp_illegal;
  logic [31:0] acc;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  err;
    logic        ill;
    logic [31:0] acc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_cmd     (req_cmd),
    .req_use_acc (req_use_acc),
    .acc_clear   (acc_clear),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_cmd     (alu_cmd),
    .alu_result  (alu_result),
    .alu_error   (alu_error),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_error   (rsp_error),
    .rsp_illegal (rsp_illegal),
    .acc         (acc),
    .busy        (busy)
  );

  // ALU environment model
  always_comb begin
    alu_result = '0;
    alu_error  = '0;
    case (alu_cmd)
      4'd0: alu_result = 32'(alu_a) + 32'(alu_b);
      4'd1: begin
        alu_result   = 32'(alu_a) - 32'(alu_b);
        alu_error[0] = (alu_a < alu_b);
      end
      4'd2: alu_result = 32'(alu_a) * 32'(alu_b);
      4'd3: begin
        if (alu_b == 16'd0) alu_error = 2'b10;
        else alu_result = 32'(alu_a / alu_b);
      end
      4'd4: begin
        if (alu_b == 16'd0) alu_error = 2'b10;
        else alu_result = 32'(alu_a % alu_b);
      end
      default: ;
    endcase
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_rsp: got %h expected none",
                 rsp_result);
      end else begin
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_error", 32'(rsp_error), 32'(e.err));
        chk("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
        chk("acc", acc, e.acc);
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] r,
                              input logic [1:0] er,
                              input logic il,
                              input logic [31:0] ac);
    exp_t e;
    e.res = r;
    e.err = er;
    e.ill = il;
    e.acc = ac;
    return e;
  endfunction

  // Called at posedge+1; returns at accept edge + 1
  task automatic send(input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [3:0]  cmd,
                      input logic ua,
                      input logic clr,
                      input logic push,
                      input exp_t e);
    bit ok;
    req_a       = a;
    req_b       = b;
    req_cmd     = cmd;
    req_use_acc = ua;
    acc_clear   = clr;
    req_valid   = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: got 0 expected 1");
    end
    @(posedge clk);
    if (push) sb.push_back(e);
    #1;
    req_valid   = 1'b0;
    acc_clear   = 1'b0;
    req_use_acc = 1'b0;
  endtask

  task automatic lat(input int exp);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    chk("latency", 32'(n), 32'(exp));
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_alu_cmd"}, 32'(alu_cmd), 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    chk({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_acc"}, acc, 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t nul;
    nul         = mk(32'd0, 2'b00, 1'b0, 32'd0);
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_a       = '0;
    req_b       = '0;
    req_cmd     = '0;
    req_use_acc = 1'b0;
    acc_clear   = 1'b0;
    rsp_ready   = 1'b1;
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add
    send(16'h7FFF, 16'h0003, 4'd0, 0, 0, 1,
         mk(32'h8002, 2'b00, 0, 32'h8002));
    chk("add_alu_a", 32'(alu_a), 32'h7FFF);
    chk("add_alu_cmd", 32'(alu_cmd), 32'd0);
    lat(3);
    drain();

    // chained multiply from acc
    send(16'h1234, 16'h0002, 4'd2, 1, 0, 1,
         mk(32'h10004, 2'b00, 0, 32'h10004));
    chk("mul_alu_a", 32'(alu_a), 32'h8002);
    lat(3);
    drain();

    // divide by zero keeps acc
    send(16'd10, 16'd0, 4'd3, 0, 0, 1,
         mk(32'd0, 2'b10, 0, 32'h10004));
    lat(3);
    drain();

    // illegal command: operands untouched
    send(16'h0000, 16'h0005, 4'd7, 0, 0, 1,
         mk(32'd0, 2'b00, 1, 32'h10004));
    chk("ill_alu_a", 32'(alu_a), 32'd10);
    chk("ill_alu_b", 32'(alu_b), 32'd0);
    chk("ill_alu_cmd", 32'(alu_cmd), 32'd3);
    lat(1);
    drain();

    // sub with borrow: overflow still updates acc
    send(16'd5, 16'd7, 4'd1, 0, 0, 1,
         mk(32'hFFFF_FFFE, 2'b01, 0, 32'hFFFF_FFFE));
    lat(3);
    drain();

    // use_acc with same-edge clear uses pre-edge acc
    send(16'h0000, 16'h0003, 4'd0, 1, 1, 1,
         mk(32'h10001, 2'b00, 0, 32'h10001));
    chk("clr_alu_a", 32'(alu_a), 32'hFFFE);
    chk("clr_acc_now", acc, 32'd0);
    lat(3);
    drain();

    // backpressure
    rsp_ready = 1'b0;
    send(16'd1, 16'd2, 4'd0, 0, 0, 1,
         mk(32'd3, 2'b00, 0, 32'd3));
    lat(3);
    @(posedge clk);
    #1;
    req_a     = 16'd17;
    req_b     = 16'd5;
    req_cmd   = 4'd4;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", rsp_result, 32'd3);
      chk("bp_alu_a", 32'(alu_a), 32'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send(16'd17, 16'd5, 4'd4, 0, 0, 1,
         mk(32'd2, 2'b00, 0, 32'd2));
    chk("bp_sb_popped", 32'(sb.size()), 32'd1);
    chk("bp2_alu_a", 32'(alu_a), 32'd17);
    lat(3);
    drain();

    // clear on the capture edge wins
    send(16'd4, 16'd4, 4'd0, 0, 0, 1,
         mk(32'd8, 2'b00, 0, 32'd0));
    @(posedge clk);
    #1 acc_clear = 1'b1;
    @(posedge clk);
    #1 acc_clear = 1'b0;
    chk("capclr_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();

    send(16'd6, 16'd6, 4'd0, 0, 0, 1,
         mk(32'd12, 2'b00, 0, 32'd12));
    lat(3);
    drain();

    // reset during SETTLE aborts the request
    send(16'd9, 16'd9, 4'd0, 0, 0, 0, nul);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    send(16'd1, 16'd1, 4'd0, 0, 0, 1,
         mk(32'd2, 2'b00, 0, 32'd2));
    lat(3);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
